// File: rtl/fft_mag_framer.sv
// Squared-magnitude framer: FFT bins in, gap-free NSamples-long magnitude bursts out via a ping-pong buffer.
// Optional FFT_MAG_BITREV_EN: bins arrive bit-reversed; write address is the bit-reversed arrival count.
module fft_mag_framer #(
  parameter int NSamples = 256,
  parameter int DW       = 16,
  parameter int W        = 2*DW+1,
  parameter int NBits    = $clog2(NSamples)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [DW-1:0] fft_re,
  input  logic signed [DW-1:0] fft_im,
  input  logic                 fft_valid,
  input  logic                 fft_sop,
  output logic                 fft_ready,
  output logic [W-1:0]         mag,
  output logic                 mag_valid,
  output logic                 frame_drop
);

  typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL, B_READING} bank_t;
  typedef enum logic {WAIT_SOP, FILL} wr_t;
  typedef enum logic {IDLE, STREAM} rd_t;

  logic [W-1:0] mem [2*NSamples];

  bank_t bank_st [2];
  bank_t bank_nxt [2];

  wr_t              wr_state, wr_state_nxt;
  logic [NBits-1:0] wr_cnt, wr_cnt_nxt;
  logic             wr_bank, wr_bank_nxt;
  logic             accept, take, drop, wr_last;
  logic [NBits-1:0] wr_pos, wr_addr;

  rd_t              rd_state, rd_state_nxt;
  logic [NBits-1:0] rd_cnt, rd_cnt_nxt, rd_addr;
  logic             rd_bank, rd_start, rd_done, rd_emit;

  logic signed [2*DW-1:0] sq_re, sq_im;
  logic                   p1_valid, p1_last, p1_bank;
  logic [NBits-1:0]       p1_addr;
  logic [W-1:0]           p2_sum;
  logic                   p2_valid, p2_last, p2_bank;
  logic [NBits-1:0]       p2_addr;

  logic ready_nxt;

  function automatic logic [NBits-1:0] bitrev(input logic [NBits-1:0] a);
    logic [NBits-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NBits; i++) r[i] = a[NBits-1-i];
    return r;
  endfunction

  // Write FSM: a sop always lands at position 0, restarting a partial frame in place.
  always_comb begin
    wr_state_nxt = wr_state;
    wr_cnt_nxt   = wr_cnt;
    wr_bank_nxt  = wr_bank;
    accept       = fft_valid && fft_ready;
    take         = 1'b0;
    drop         = 1'b0;
    wr_last      = 1'b0;
    wr_pos       = fft_sop ? '0 : wr_cnt;
    case (wr_state)
      WAIT_SOP: begin
        if (accept && fft_sop) begin
          take         = 1'b1;
          wr_cnt_nxt   = NBits'(1);
          wr_state_nxt = FILL;
        end
      end
      FILL: begin
        if (accept) begin
          take = 1'b1;
          if (fft_sop) begin
            drop       = 1'b1;
            wr_cnt_nxt = NBits'(1);
          end else begin
            wr_cnt_nxt = wr_cnt + 1'b1;
            if (wr_cnt == '1) begin
              wr_last      = 1'b1;
              wr_bank_nxt  = ~wr_bank;
              wr_state_nxt = WAIT_SOP;
            end
          end
        end
      end
    endcase
`ifdef FFT_MAG_BITREV_EN
    wr_addr = bitrev(wr_pos);
`else
    wr_addr = wr_pos;
`endif
  end

  // Read FSM: the IDLE->STREAM cycle already emits word 0 so the burst follows FULL by one cycle.
  always_comb begin
    rd_state_nxt = rd_state;
    rd_cnt_nxt   = rd_cnt;
    rd_addr      = rd_cnt;
    rd_start     = 1'b0;
    rd_done      = 1'b0;
    rd_emit      = 1'b0;
    case (rd_state)
      IDLE: begin
        if (bank_st[rd_bank] == B_FULL) begin
          rd_start     = 1'b1;
          rd_emit      = 1'b1;
          rd_addr      = '0;
          rd_cnt_nxt   = NBits'(1);
          rd_state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (rd_cnt == '0) begin
          rd_done      = 1'b1;
          rd_state_nxt = IDLE;
        end else begin
          rd_emit    = 1'b1;
          rd_cnt_nxt = rd_cnt + 1'b1;
        end
      end
    endcase
  end

  // Ready looks at next-cycle bank ownership, so a release is visible to the writer on the following cycle.
  always_comb begin
    bank_nxt[0] = bank_st[0];
    bank_nxt[1] = bank_st[1];
    if (take && fft_sop)      bank_nxt[wr_bank] = B_FILLING;
    if (p2_valid && p2_last)  bank_nxt[p2_bank] = B_FULL;
    if (rd_start)             bank_nxt[rd_bank] = B_READING;
    if (rd_done)              bank_nxt[rd_bank] = B_FREE;
    ready_nxt = (bank_nxt[wr_bank_nxt] == B_FREE) || (bank_nxt[wr_bank_nxt] == B_FILLING);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_state   <= WAIT_SOP;
      wr_cnt     <= '0;
      wr_bank    <= 1'b0;
      rd_state   <= IDLE;
      rd_cnt     <= '0;
      rd_bank    <= 1'b0;
      bank_st[0] <= B_FREE;
      bank_st[1] <= B_FREE;
      fft_ready  <= 1'b1;
      frame_drop <= 1'b0;
      mag        <= '0;
      mag_valid  <= 1'b0;
      sq_re      <= '0;
      sq_im      <= '0;
      p1_valid   <= 1'b0;
      p1_last    <= 1'b0;
      p1_bank    <= 1'b0;
      p1_addr    <= '0;
      p2_sum     <= '0;
      p2_valid   <= 1'b0;
      p2_last    <= 1'b0;
      p2_bank    <= 1'b0;
      p2_addr    <= '0;
    end else begin
      wr_state   <= wr_state_nxt;
      wr_cnt     <= wr_cnt_nxt;
      wr_bank    <= wr_bank_nxt;
      rd_state   <= rd_state_nxt;
      rd_cnt     <= rd_cnt_nxt;
      rd_bank    <= rd_done ? ~rd_bank : rd_bank;
      bank_st[0] <= bank_nxt[0];
      bank_st[1] <= bank_nxt[1];
      fft_ready  <= ready_nxt;
      frame_drop <= drop;
      mag_valid  <= rd_emit;
      mag        <= rd_emit ? mem[{rd_bank, rd_addr}] : '0;

      sq_re    <= fft_re * fft_re;
      sq_im    <= fft_im * fft_im;
      p1_valid <= take;
      p1_last  <= wr_last;
      p1_bank  <= wr_bank;
      p1_addr  <= wr_addr;

      p2_sum   <= W'($unsigned(sq_re)) + W'($unsigned(sq_im));
      p2_valid <= p1_valid;
      p2_last  <= p1_last;
      p2_bank  <= p1_bank;
      p2_addr  <= p1_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (p2_valid) mem[{p2_bank, p2_addr}] <= p2_sum;
  end

endmodule

// File: tb/tb_fft_mag_framer.sv
// Randomized bench for fft_mag_framer against a frame-level reference model of transfers and bursts.
module tb_fft_mag_framer;
  localparam int N  = 256;
  localparam int DW = 16;
  localparam int W  = 2*DW+1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic signed [DW-1:0] fft_re, fft_im;
  logic                 fft_valid, fft_sop;
  logic                 fft_ready;
  logic [W-1:0]         mag;
  logic                 mag_valid;
  logic                 frame_drop;

  fft_mag_framer #(.NSamples(N), .DW(DW), .W(W)) dut (
    .clk(clk), .reset(reset), .fft_re(fft_re), .fft_im(fft_im),
    .fft_valid(fft_valid), .fft_sop(fft_sop), .fft_ready(fft_ready),
    .mag(mag), .mag_valid(mag_valid), .frame_drop(frame_drop)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned brev8(input int unsigned c);
    int unsigned r = 0;
    for (int unsigned i = 0; i < 8; i++) if (c[i]) r |= (1 << (7 - i));
    return r;
  endfunction

  // Bin index k carried by the c-th transfer of a frame.
  function automatic int unsigned bin_of(input int unsigned c);
`ifdef FFT_MAG_BITREV_EN
    return brev8(c);
`else
    return c;
`endif
  endfunction

  // Reference model state
  longint      exp_q[$];
  longint      cur[N];
  int unsigned in_cnt = 0;
  bit          in_frame = 0;
  int          negcount = 0;
  int          drop_at = -10;
  int          run = 0;
  bit          lat_check = 0;
  int          lat_at = -1;
  bit          saw_nr = 0;
  bit          mon_en = 0;

  task automatic model_xfer();
    int unsigned k;
    if (fft_sop) begin
      if (in_frame) drop_at = negcount + 1;
      in_frame = 1;
      in_cnt   = 0;
    end
    if (in_frame) begin
      k = bin_of(in_cnt);
      cur[k] = longint'(fft_re) * longint'(fft_re) + longint'(fft_im) * longint'(fft_im);
      in_cnt++;
      if (in_cnt == N) begin
        for (int i = 0; i < N; i++) exp_q.push_back(cur[i]);
        in_frame = 0;
        if (lat_check) lat_at = negcount + 4;
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      negcount++;
      check("frame_drop", 64'(frame_drop), 64'(negcount == drop_at));
      if (mag_valid) begin
        if (run == 0 && lat_check) begin
          check("latency", 64'(negcount), 64'(lat_at));
          lat_check = 0;
        end
        run++;
        if (exp_q.size() == 0) check("unexpected_burst", 64'(1), 64'(0));
        else check("mag", 64'(mag), exp_q.pop_front());
      end else begin
        check("mag_idle", 64'(mag), 64'(0));
        if (run != 0) begin
          check("burst_len", 64'(run), 64'(N));
          run = 0;
        end
      end
      if (!fft_ready) saw_nr = 1;
      if (fft_valid && fft_ready) model_xfer();
    end
  end

  logic signed [DW-1:0] fr_re[N];
  logic signed [DW-1:0] fr_im[N];

  task automatic rand_frame();
    for (int i = 0; i < N; i++) begin
      fr_re[i] = DW'($urandom);
      fr_im[i] = DW'($urandom);
    end
  endtask

  task automatic send_bin(input logic signed [DW-1:0] re, input logic signed [DW-1:0] im, input bit sop);
    bit acc;
    fft_re = re; fft_im = im; fft_sop = sop; fft_valid = 1'b1;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      acc = fft_ready;
      @(posedge clk); #1;
      if (acc) break;
      if (t > 2000) begin
        check("ready_timeout", 64'(0), 64'(1));
        break;
      end
    end
    fft_valid = 1'b0; fft_sop = 1'b0;
  endtask

  task automatic send_frame(input bit gap3, input int stop_at);
    int unsigned k;
    for (int c = 0; c < stop_at; c++) begin
      k = bin_of(c);
      send_bin(fr_re[k], fr_im[k], c == 0);
      if (gap3 && (c % 3 == 2)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 3000; t++) begin
      if (exp_q.size() == 0 && !mag_valid && run == 0) break;
      @(posedge clk); #1;
    end
    check("drain", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    reset = 1'b0; fft_re = '0; fft_im = '0; fft_valid = 1'b0; fft_sop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(fft_ready), 64'(1));
    check("rst_mag_valid", 64'(mag_valid), 64'(0));
    check("rst_mag", 64'(mag), 64'(0));
    check("rst_frame_drop", 64'(frame_drop), 64'(0));
    reset = 1'b1;
    mon_en = 1;
    @(posedge clk); #1;

    // re = k, im = 0, with first-burst latency check
    for (int i = 0; i < N; i++) begin fr_re[i] = DW'(i); fr_im[i] = '0; end
    lat_check = 1;
    send_frame(0, N);
    wait_drain();
    check("latency_seen", 64'(lat_check), 64'(0));

    // most negative corner
    rand_frame();
    fr_re[7] = 16'sh8000; fr_im[7] = 16'sh8000;
    fr_re[N-1] = 16'sh8000; fr_im[N-1] = 16'sh8000;
    send_frame(0, N);
    wait_drain();

    // input gaps every third cycle
    rand_frame();
    send_frame(1, N);
    wait_drain();

    // sop reasserted at bin 100
    rand_frame();
    send_frame(0, 100);
    rand_frame();
    send_frame(0, N);
    wait_drain();

    // three frames back-to-back
    saw_nr = 0;
    for (int f = 0; f < 3; f++) begin
      rand_frame();
      send_frame(0, N);
    end
    wait_drain();
    check("ready_fell", 64'(saw_nr), 64'(1));

    // reset in the middle of a burst
    rand_frame();
    send_frame(0, N);
    for (int t = 0; t < 100; t++) begin
      if (mag_valid) break;
      @(posedge clk); #1;
    end
    repeat (49) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_valid", 64'(mag_valid), 64'(0));
    check("rst_mid_mag", 64'(mag), 64'(0));
    check("rst_mid_ready", 64'(fft_ready), 64'(1));
    exp_q.delete();
    run = 0; in_frame = 0; in_cnt = 0; lat_check = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 20; i++) send_bin(DW'($urandom), DW'($urandom), 1'b0);
    repeat (300) @(posedge clk);
    #1;
    rand_frame();
    send_frame(0, N);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
